// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D-cache memory port arbiter: FSM encoding and owner ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    function automatic state_t busy_state(input logic owner);
        return (owner == OWN_D) ? D_BUSY : I_BUSY;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational owner pick between the I- and D-cache strobes.
// Fixed D-over-I priority, or round-robin on ties when ARB_RR_EN is defined.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_strobe,
    input  logic d_strobe,
`ifdef ARB_RR_EN
    input  logic rr_last,
`endif
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        grant_valid = i_strobe | d_strobe;
        grant_owner = OWN_I;
        if (d_strobe) begin
            grant_owner = OWN_D;
`ifdef ARB_RR_EN
            if (i_strobe && rr_last == OWN_D) begin
                grant_owner = OWN_I;
            end
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-cache and D-cache; grants one request at a time.
// Optional macro ARB_RR_EN selects round-robin tie breaking instead of D-over-I priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               clrn,

    input  logic               i_strobe,
    input  logic [A_WIDTH-1:0] i_a,
    output logic               i_ready,
    output logic [31:0]        i_dout,

    input  logic               d_strobe,
    input  logic               d_rw,
    input  logic [3:0]         d_wen,
    input  logic [A_WIDTH-1:0] d_a,
    input  logic [31:0]        d_din,
    output logic               d_ready,
    output logic [31:0]        d_dout,

    output logic               m_strobe,
    output logic               m_rw,
    output logic [3:0]         m_wen,
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    input  logic [31:0]        m_dout,
    input  logic               m_ready
);

    state_t state;
    logic   grant_valid;
    logic   grant_owner;

`ifdef ARB_RR_EN
    logic rr_last;
`endif

    arb_pick u_pick (
        .i_strobe    (i_strobe),
        .d_strobe    (d_strobe),
`ifdef ARB_RR_EN
        .rr_last     (rr_last),
`endif
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // NOTE: ready is combinational so the owner sees completion in the m_ready cycle itself.
    assign i_ready = m_ready & (state == I_BUSY);
    assign d_ready = m_ready & (state == D_BUSY);

    // Read data is unqualified; each cache qualifies it with its own ready.
    assign i_dout = m_dout;
    assign d_dout = m_dout;

    // NOTE: all state here uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            m_strobe <= 1'b0;
            m_rw     <= 1'b0;
            m_wen    <= 4'b0000;
            m_a      <= '0;
            m_din    <= '0;
`ifdef ARB_RR_EN
            rr_last  <= OWN_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        m_strobe <= 1'b1;
                        state    <= busy_state(grant_owner);
`ifdef ARB_RR_EN
                        rr_last  <= grant_owner;
`endif
                        if (grant_owner == OWN_D) begin
                            m_a   <= d_a;
                            m_rw  <= d_rw;
                            m_wen <= d_wen;
                            m_din <= d_din;
                        end else begin
                            m_a   <= i_a;
                            m_rw  <= 1'b0;
                            m_wen <= 4'b0000;
                            m_din <= '0;
                        end
                    end
                end
                // m_ready wins over a same-cycle strobe drop: that is a normal completion.
                I_BUSY: begin
                    if (m_ready) begin
                        m_strobe <= 1'b0;
                        state    <= IDLE;
                    end else if (!i_strobe) begin
                        state    <= DRAIN;
                    end
                end
                D_BUSY: begin
                    if (m_ready) begin
                        m_strobe <= 1'b0;
                        state    <= IDLE;
                    end else if (!d_strobe) begin
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        m_strobe <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    m_strobe <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    a_strobe_low_in_idle: assert property (
        @(posedge clk) disable iff (!clrn) (state == IDLE) |-> !m_strobe
    );

    a_port_held_while_busy: assert property (
        @(posedge clk) disable iff (!clrn)
        (state != IDLE && !m_ready) |=> (m_strobe && $stable(m_a) && $stable(m_rw) && $stable(m_wen))
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written corner sequences.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic        i_strobe;
    logic [31:0] i_a;
    logic        i_ready;
    logic [31:0] i_dout;
    logic        d_strobe;
    logic        d_rw;
    logic [3:0]  d_wen;
    logic [31:0] d_a;
    logic [31:0] d_din;
    logic        d_ready;
    logic [31:0] d_dout;
    logic        m_strobe;
    logic        m_rw;
    logic [3:0]  m_wen;
    logic [31:0] m_a;
    logic [31:0] m_din;
    logic [31:0] m_dout;
    logic        m_ready;

    always #5 clk = ~clk;

    mem_port_arbiter #(.A_WIDTH(32)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .i_strobe (i_strobe),
        .i_a      (i_a),
        .i_ready  (i_ready),
        .i_dout   (i_dout),
        .d_strobe (d_strobe),
        .d_rw     (d_rw),
        .d_wen    (d_wen),
        .d_a      (d_a),
        .d_din    (d_din),
        .d_ready  (d_ready),
        .d_dout   (d_dout),
        .m_strobe (m_strobe),
        .m_rw     (m_rw),
        .m_wen    (m_wen),
        .m_a      (m_a),
        .m_din    (m_din),
        .m_dout   (m_dout),
        .m_ready  (m_ready)
    );

    typedef struct {
        logic        own;
        logic [31:0] a;
        logic        rw;
        logic [3:0]  wen;
        logic [31:0] din;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        i_req;
        logic [31:0] i_a;
        logic        d_req;
        logic        d_rw;
        logic [3:0]  d_wen;
        logic [31:0] d_a;
        logic [31:0] d_din;
        int          lat;
        logic        drop_with_ready;
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic last_served = OWN_I;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic tie_winner();
`ifdef ARB_RR_EN
        return (last_served == OWN_D) ? OWN_I : OWN_D;
`else
        return OWN_D;
`endif
    endfunction

    task automatic push_i(input logic [31:0] a, input logic [31:0] rdata);
        sb.push_back('{OWN_I, a, 1'b0, 4'h0, 32'h0, rdata});
    endtask

    task automatic push_d(input logic [31:0] a, input logic rw, input logic [3:0] wen,
                          input logic [31:0] din, input logic [31:0] rdata);
        sb.push_back('{OWN_D, a, rw, wen, din, rdata});
    endtask

    task automatic drop(input logic own);
        if (own == OWN_I) i_strobe = 1'b0;
        else              d_strobe = 1'b0;
    endtask

    // Waits (bounded) for the next grant, pops the scoreboard and compares the latched port.
    task automatic wait_grant(output exp_t e, output bit ok);
        int waited = 0;
        ok = 1'b0;
        e  = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0};
        while (waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
            if (m_strobe) break;
        end
        if (!m_strobe) begin
            check("grant_timeout", 32'(m_strobe), 32'd1);
            return;
        end
        check("grant_latency", 32'(waited), 32'd1);
        if (sb.size() == 0) begin
            check("unexpected_grant", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        ok = 1'b1;
        last_served = e.own;
        check("m_a", m_a, e.a);
        check("m_rw", 32'(m_rw), 32'(e.rw));
        check("m_wen", 32'(m_wen), 32'(e.wen));
        if (e.rw) check("m_din", m_din, e.din);
    endtask

    // Holds the transaction lat cycles after m_strobe rises, then pulses m_ready.
    task automatic complete(input exp_t e, input int lat, input logic drop_with_ready);
        for (int k = 1; k < lat; k++) begin
            check("busy_strobe_held", 32'(m_strobe), 32'd1);
            check("busy_a_held", m_a, e.a);
            check("busy_no_ready", 32'({i_ready, d_ready}), 32'd0);
            @(negedge clk);
            #1;
        end
        m_ready = 1'b1;
        m_dout  = e.rdata;
        if (drop_with_ready) drop(e.own);
        #1;
        if (e.own == OWN_I) begin
            check("i_ready_pulse", 32'(i_ready), 32'd1);
            check("d_ready_nonowner", 32'(d_ready), 32'd0);
            check("i_dout", i_dout, e.rdata);
        end else begin
            check("d_ready_pulse", 32'(d_ready), 32'd1);
            check("i_ready_nonowner", 32'(i_ready), 32'd0);
            check("d_dout", d_dout, e.rdata);
        end
        @(negedge clk);
        m_ready = 1'b0;
        m_dout  = 32'h0;
        drop(e.own);
        #1;
        check("idle_gap_strobe", 32'(m_strobe), 32'd0);
        check("idle_gap_ready", 32'({i_ready, d_ready}), 32'd0);
    endtask

    task automatic run_vector(input vec_t v);
        exp_t e;
        bit   ok;
        int   n;
        i_strobe = v.i_req;
        i_a      = v.i_a;
        d_strobe = v.d_req;
        d_rw     = v.d_rw;
        d_wen    = v.d_wen;
        d_a      = v.d_a;
        d_din    = v.d_din;
        n = 0;
        if (v.i_req && v.d_req && tie_winner() == OWN_I) begin
            push_i(v.i_a, v.i_rdata);
            push_d(v.d_a, v.d_rw, v.d_wen, v.d_din, v.d_rdata);
            n = 2;
        end else begin
            if (v.d_req) begin push_d(v.d_a, v.d_rw, v.d_wen, v.d_din, v.d_rdata); n++; end
            if (v.i_req) begin push_i(v.i_a, v.i_rdata); n++; end
        end
        for (int t = 0; t < n; t++) begin
            wait_grant(e, ok);
            if (!ok) return;
            complete(e, v.lat, v.drop_with_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        exp_t e;
        bit   ok;

        //          i_req  i_a           d_req d_rw  d_wen  d_a           d_din         lat drop  i_rdata       d_rdata
        vecs[0] = '{1'b1, 32'hBFC00000, 1'b0, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 3, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 32'hBFC00004, 1'b1, 1'b1, 4'hF, 32'h80001000, 32'h12345678, 2, 1'b0, 32'h0BADF00D, 32'h0};
        vecs[2] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 4'h0, 32'h80002000, 32'h00000000, 1, 1'b0, 32'h0,        32'hCAFEF00D};
        vecs[3] = '{1'b1, 32'hBFC00010, 1'b1, 1'b0, 4'h0, 32'h80003000, 32'h00000000, 2, 1'b0, 32'h11112222, 32'h33334444};
        vecs[4] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 4'h3, 32'h80005004, 32'hA5A55A5A, 4, 1'b1, 32'h0,        32'h0};

        clrn = 1'b0; i_strobe = 1'b0; i_a = '0; d_strobe = 1'b0; d_rw = 1'b0;
        d_wen = '0; d_a = '0; d_din = '0; m_dout = '0; m_ready = 1'b0;
        #12;
        check("rst_m_strobe", 32'(m_strobe), 32'd0);
        check("rst_m_rw", 32'(m_rw), 32'd0);
        check("rst_m_wen", 32'(m_wen), 32'd0);
        check("rst_m_a", m_a, 32'd0);
        check("rst_m_din", m_din, 32'd0);
        check("rst_readies", 32'({i_ready, d_ready}), 32'd0);
        @(negedge clk);
        clrn = 1'b1;

        for (int v = 0; v < 5; v++) run_vector(vecs[v]);

        // Spurious m_ready while idle: no ready, no grant.
        m_ready = 1'b1;
        m_dout  = 32'h5555AAAA;
        #1;
        check("spurious_no_ready", 32'({i_ready, d_ready}), 32'd0);
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        check("spurious_no_strobe", 32'(m_strobe), 32'd0);
        run_vector('{1'b1, 32'hBFC00020, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2, 1'b0, 32'h76543210, 32'h0});

        // D read abandoned two cycles in: memory still completes, nobody gets ready.
        d_strobe = 1'b1; d_rw = 1'b0; d_wen = 4'h0; d_a = 32'h80004000; d_din = 32'h0;
        push_d(32'h80004000, 1'b0, 4'h0, 32'h0, 32'h99999999);
        wait_grant(e, ok);
        @(negedge clk);
        #1;
        d_strobe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("drain_strobe_held", 32'(m_strobe), 32'd1);
            check("drain_no_ready", 32'({i_ready, d_ready}), 32'd0);
        end
        m_ready = 1'b1;
        m_dout  = 32'h99999999;
        #1;
        check("drain_ready_suppressed", 32'({i_ready, d_ready}), 32'd0);
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        check("drain_back_idle", 32'(m_strobe), 32'd0);
        run_vector('{1'b1, 32'hBFC00040, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 1'b0, 32'h13579BDF, 32'h0});

        // Reset in the middle of an I transaction, then re-grant of the still-held strobe.
        i_strobe = 1'b1;
        i_a      = 32'hBFC00100;
        push_i(32'hBFC00100, 32'h24682468);
        wait_grant(e, ok);
        @(negedge clk);
        #2;
        clrn    = 1'b0;
        m_ready = 1'b1;
        #1;
        check("midrst_m_strobe", 32'(m_strobe), 32'd0);
        check("midrst_m_a", m_a, 32'd0);
        check("midrst_m_rw_wen", 32'({m_rw, m_wen}), 32'd0);
        check("midrst_m_din", m_din, 32'd0);
        check("midrst_readies", 32'({i_ready, d_ready}), 32'd0);
        @(negedge clk);
        m_ready = 1'b0;
        clrn    = 1'b1;
        last_served = OWN_I;
        push_i(32'hBFC00100, 32'h24682468);
        wait_grant(e, ok);
        if (ok) complete(e, 2, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
